transpose_wdma: RTL and testbench
=================================

# transpose_wdma

Write-side DMA for the Transpose engine; the write counterpart of the Transpose read-command generator. It walks the output tensor in (h, w-burst, CH/Tout) order and issues one write command per burst on the MCIF write-request channel. Transposed data beats are forwarded to the MCIF write-data channel only once their burst command has been accepted. A `done` pulse is raised when the whole surface has been written.

## Interface

Parameters:
- `CMD_FIFO_DEPTH`, default 4: pending-burst-length FIFO depth; must be a power of 2 and at least 2.
- All other widths come from `CNN_defines.vh`: `log2_CH`, `log2Tout`, `log2_H`, `log2_W`, `AXI_BURST_LEN`, `log2AXI_BURST_LEN`, `Tout`, `MAX_DAT_DW`.

Ports (single clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins a job; ignored while `working`=1
- `base_addr`  in  32  tensor base byte address
- `surface_stride`  in  26  byte stride between Tout-channel surfaces
- `line_stride`  in  16  byte stride between rows h
- `CH_out_div_Tout`  in  `log2_CH-log2Tout`  number of channel groups; must be ≥1
- `h_out`  in  `log2_H`  row count; must be ≥1
- `w_out`  in  `log2_W`  pixels per row; must be ≥1
- `Trans_dat_vld` / `Trans_dat_rdy`  in / out  1  transposed data stream handshake
- `Trans_dat_pd`  in  `Tout*MAX_DAT_DW`  data beat
- `Trans2mcif_wr_req_vld` / `_rdy`  out / in  1  write-command handshake
- `Trans2mcif_wr_req_pd`  out  `log2AXI_BURST_LEN+64`  {len, base_addr, offset}
- `Trans2mcif_wr_dat_vld` / `_rdy`  out / in  1  write-data handshake
- `Trans2mcif_wr_dat_pd`  out  `Tout*MAX_DAT_DW`  equals `Trans_dat_pd`
- `Trans2mcif_wr_dat_last`  out  1  final beat of the current burst
- `Trans2mcif_wr_ack`  in  1  one pulse per completed burst; used only with the ack macro defined
- `working`  out  1  job in progress
- `done`  out  1  one-cycle completion pulse

## Operation

- Counters, innermost first:
  - `ch_cnt` runs 0..`CH_out_div_Tout`-1.
  - `wb_cnt` runs 0..(`w_out`-1)>>`log2AXI_BURST_LEN`.
  - `h_cnt` runs 0..`h_out`-1.
- All counters advance on command accept (`wr_req_vld & wr_req_rdy`) and wrap to 0 when they reach their maximum.
- Offset is formed with full 32-bit arithmetic, no truncation: offset = h_cnt·line_stride + ch_cnt·surface_stride + wb_cnt·(AXI_BURST_LEN·Tout·MAX_DAT_DW/8).
  - Each term is kept as a running 32-bit accumulator; no multipliers.
- Burst length: len = (w_out-1)[log2AXI_BURST_LEN-1:0] on the last w-burst of a row, otherwise AXI_BURST_LEN-1.
- On every command accept, len is pushed into the command FIFO.
- `wr_req_vld` = `working` & !`cmd_issued_all` & !`fifo_full`.
- Data path:
  - `wr_dat_vld` = `Trans_dat_vld` & !`fifo_empty`.
  - `Trans_dat_rdy` = `wr_dat_rdy` & !`fifo_empty`.
  - `beat_cnt` counts accepted beats.
  - `wr_dat_last` = (`beat_cnt` == FIFO head len).
  - On an accepted last beat: pop the FIFO and clear `beat_cnt`.
- `cmd_issued_all` sets when the command with maximal h, w-burst and ch is accepted.
- `done` asserts one cycle after the final last-beat accept, provided `cmd_issued_all`=1 and the FIFO is empty after the pop. It clears `working`, `cmd_issued_all` and all counters.
- FIFO push and pop in the same cycle are legal when full; occupancy is unchanged.
- `start` coincident with `done` starts a new job (start wins).

## Timing

- Reset values: `working`, `done`, `wr_req_vld`, `wr_dat_vld`, `wr_dat_last` and `Trans_dat_rdy` are all 0; all counters are 0; FIFO is empty.
- Reset asserted mid-job aborts immediately; no `done` is produced.
- First command is valid in the cycle after `start`.
- Data path is combinational pass-through: zero latency, no beat buffering.
- Command payload must be stable while `vld` & !`rdy`.
- `done` is a registered one-cycle pulse; `working` falls in the same cycle that `done` is high.

## Configuration

- `TRANSPOSE_WDMA_WR_ACK_EN` defined:
  - An outstanding-burst counter increments on command accept and decrements on `Trans2mcif_wr_ack`.
  - Simultaneous increment and decrement leaves it unchanged.
  - `done` additionally requires the counter to be 0 after the final data beat, so it may occur later than in the undefined case.
- Undefined: `Trans2mcif_wr_ack` is ignored and the counter is not instantiated.

## Structure

- Burst byte stride and payload field widths are shared localparams in the Transpose defines section of `CNN_defines.vh`.
- One sub-module: `transpose_wdma_len_fifo`, a synchronous FIFO of width `log2AXI_BURST_LEN` and depth `CMD_FIFO_DEPTH`, with full/empty flags and same-cycle push/pop.

## Test plan

Bench build: AXI_BURST_LEN=8, Tout=32, MAX_DAT_DW=16, so the burst stride is 512 bytes.

- **Single burst.** CH_out_div_Tout=1, h=1, w=8 → one command {len=7, base, offset 0}; 8 beats with `last` on beat 8; `done` 1 cycle later.
- **Partial tail.** w=10, CH=2, h=1 → commands: offsets 0 and surface_stride with len 7, then 512 and 512+surface_stride with len 1.
- **Rows.** h=3, line_stride=0x1000, w=8, CH=1 → offsets 0x0000, 0x1000, 0x2000; 24 beats total.
- **Backpressure.** `wr_req_rdy` held at 0 for 20 cycles while data is valid → `Trans_dat_rdy` stays 0 until the first command is accepted. With `wr_dat_rdy` held at 0 → FIFO fills to 4 and `wr_req_vld` drops.
- **Reset.** `rst` pulsed mid-job → all outputs 0 the next cycle; a new `start` replays from offset 0.
- **Ack macro.** With `TRANSPOSE_WDMA_WR_ACK_EN` defined, the last ack delayed 5 cycles after the final beat → `done` occurs only after that ack.

Source files
------------

// File: rtl/transpose_wdma_pkg.sv
// Shared sizing for the Transpose write DMA: build-time tensor widths, burst
// geometry and the write-request payload layout.
package transpose_wdma_pkg;

  localparam int unsigned AXI_BURST_LEN     = 8;
  localparam int unsigned log2AXI_BURST_LEN = 3;
  localparam int unsigned Tout              = 32;
  localparam int unsigned log2Tout          = 5;
  localparam int unsigned MAX_DAT_DW        = 16;
  localparam int unsigned log2_CH           = 8;
  localparam int unsigned log2_H            = 8;
  localparam int unsigned log2_W            = 8;

  localparam int unsigned LEN_W = log2AXI_BURST_LEN;
  localparam int unsigned CHG_W = log2_CH - log2Tout;
  localparam int unsigned WB_W  = log2_W - log2AXI_BURST_LEN;
  localparam int unsigned DAT_W = Tout * MAX_DAT_DW;
  localparam int unsigned REQ_W = LEN_W + 64;

  // Bytes covered by one full burst along w.
  localparam logic [31:0] BURST_STRIDE = 32'(AXI_BURST_LEN * Tout * MAX_DAT_DW / 8);

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [31:0]      base_addr;
    logic [31:0]      offset;
  } wr_req_t;

  function automatic logic [31:0] offset_sum(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
    return a + b + c;
  endfunction

endpackage

// File: rtl/transpose_wdma_len_fifo.sv
// Pending-burst length FIFO: synchronous, power-of-2 depth, same-cycle push/pop
// allowed even when full.
module transpose_wdma_len_fifo #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot being written, so push is accepted when full too.
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/transpose_wdma.sv
// Transpose write DMA: walks (h, w-burst, CH/Tout), issues one MCIF write command per
// burst and forwards data beats only for accepted bursts. Optional feature macro
// TRANSPOSE_WDMA_WR_ACK_EN holds done until every burst has been acknowledged.
module transpose_wdma
  import transpose_wdma_pkg::*;
#(
  parameter int unsigned CMD_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [25:0]       surface_stride,
  input  logic [15:0]       line_stride,
  input  logic [CHG_W-1:0]  CH_out_div_Tout,
  input  logic [log2_H-1:0] h_out,
  input  logic [log2_W-1:0] w_out,
  input  logic              Trans_dat_vld,
  output logic              Trans_dat_rdy,
  input  logic [DAT_W-1:0]  Trans_dat_pd,
  output logic              Trans2mcif_wr_req_vld,
  input  logic              Trans2mcif_wr_req_rdy,
  output logic [REQ_W-1:0]  Trans2mcif_wr_req_pd,
  output logic              Trans2mcif_wr_dat_vld,
  input  logic              Trans2mcif_wr_dat_rdy,
  output logic [DAT_W-1:0]  Trans2mcif_wr_dat_pd,
  output logic              Trans2mcif_wr_dat_last,
  input  logic              Trans2mcif_wr_ack,
  output logic              working,
  output logic              done
);

  localparam int unsigned CntW = $clog2(CMD_FIFO_DEPTH) + 1;

  logic              working_q, working_d, issued_q, issued_d, done_q, done_d;
  logic [31:0]       base_q, base_d;
  logic [25:0]       sstride_q, sstride_d;
  logic [15:0]       lstride_q, lstride_d;
  logic [CHG_W-1:0]  ch_max_q, ch_max_d, ch_cnt_q, ch_cnt_d;
  logic [log2_H-1:0] h_max_q, h_max_d, h_cnt_q, h_cnt_d;
  logic [WB_W-1:0]   wb_max_q, wb_max_d, wb_cnt_q, wb_cnt_d;
  logic [LEN_W-1:0]  tail_len_q, tail_len_d, beat_cnt_q, beat_cnt_d;
  logic [31:0]       ch_off_q, ch_off_d, wb_off_q, wb_off_d, h_off_q, h_off_d;
  logic [log2_W-1:0] w_m1;
  logic              req_acc, dat_acc, last_acc, fin_beat, fin;
  logic              fifo_full, fifo_empty;
  logic [LEN_W-1:0]  cur_len, head_len;
  logic [CntW-1:0]   fifo_cnt;
  wr_req_t           req;

  assign w_m1     = w_out - log2_W'(1);
  assign cur_len  = (wb_cnt_q == wb_max_q) ? tail_len_q : LEN_W'(AXI_BURST_LEN - 1);
  assign req      = '{len: cur_len, base_addr: base_q,
                      offset: offset_sum(h_off_q, ch_off_q, wb_off_q)};

  assign Trans2mcif_wr_req_vld  = working_q && !issued_q && !fifo_full;
  assign Trans2mcif_wr_req_pd   = req;
  assign Trans2mcif_wr_dat_vld  = Trans_dat_vld && !fifo_empty;
  assign Trans_dat_rdy          = Trans2mcif_wr_dat_rdy && !fifo_empty;
  assign Trans2mcif_wr_dat_pd   = Trans_dat_pd;
  assign Trans2mcif_wr_dat_last = !fifo_empty && (beat_cnt_q == head_len);
  assign working                = working_q;
  assign done                   = done_q;

  assign req_acc  = Trans2mcif_wr_req_vld && Trans2mcif_wr_req_rdy;
  assign dat_acc  = Trans_dat_vld && Trans_dat_rdy;
  assign last_acc = dat_acc && Trans2mcif_wr_dat_last;
  // Final beat of the job: everything issued and this pop drains the FIFO.
  assign fin_beat = working_q && last_acc && issued_q && (fifo_cnt == CntW'(1));

  transpose_wdma_len_fifo #(
    .Width (LEN_W),
    .Depth (CMD_FIFO_DEPTH)
  ) u_len_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (req_acc),
    .wdata_i (cur_len),
    .pop_i   (last_acc),
    .rdata_o (head_len),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

`ifdef TRANSPOSE_WDMA_WR_ACK_EN
  logic [15:0] outs_q, outs_d;
  logic        data_done_q, data_done_d;

  // Outstanding-burst tracking; done waits for the count to drain after the last beat.
  always_comb begin
    outs_d = outs_q;
    if (req_acc && !Trans2mcif_wr_ack) begin
      outs_d = outs_q + 16'd1;
    end else if (!req_acc && Trans2mcif_wr_ack && (outs_q != 16'd0)) begin
      outs_d = outs_q - 16'd1;
    end
    fin         = (fin_beat || data_done_q) && (outs_d == 16'd0);
    data_done_d = (fin_beat || data_done_q) && !fin;
  end

  // Ack tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outs_q      <= '0;
      data_done_q <= 1'b0;
    end else begin
      outs_q      <= outs_d;
      data_done_q <= data_done_d;
    end
  end
`else
  logic unused_ack;
  assign unused_ack = Trans2mcif_wr_ack;
  assign fin        = fin_beat;
`endif

  // Job control, nested counters with running offset accumulators, and beat counting.
  always_comb begin
    working_d  = working_q;
    issued_d   = issued_q;
    done_d     = 1'b0;
    base_d     = base_q;
    sstride_d  = sstride_q;
    lstride_d  = lstride_q;
    ch_max_d   = ch_max_q;
    h_max_d    = h_max_q;
    wb_max_d   = wb_max_q;
    tail_len_d = tail_len_q;
    ch_cnt_d   = ch_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    h_cnt_d    = h_cnt_q;
    ch_off_d   = ch_off_q;
    wb_off_d   = wb_off_q;
    h_off_d    = h_off_q;
    beat_cnt_d = beat_cnt_q;

    if (dat_acc) begin
      beat_cnt_d = last_acc ? '0 : beat_cnt_q + LEN_W'(1);
    end

    if (req_acc) begin
      if (ch_cnt_q == ch_max_q) begin
        ch_cnt_d = '0;
        ch_off_d = '0;
        if (wb_cnt_q == wb_max_q) begin
          wb_cnt_d = '0;
          wb_off_d = '0;
          if (h_cnt_q == h_max_q) begin
            h_cnt_d  = '0;
            h_off_d  = '0;
            issued_d = 1'b1;
          end else begin
            h_cnt_d = h_cnt_q + log2_H'(1);
            h_off_d = h_off_q + {16'd0, lstride_q};
          end
        end else begin
          wb_cnt_d = wb_cnt_q + WB_W'(1);
          wb_off_d = wb_off_q + BURST_STRIDE;
        end
      end else begin
        ch_cnt_d = ch_cnt_q + CHG_W'(1);
        ch_off_d = ch_off_q + {6'd0, sstride_q};
      end
    end

    if (fin) begin
      working_d = 1'b0;
      issued_d  = 1'b0;
      done_d    = 1'b1;
      ch_cnt_d  = '0;
      wb_cnt_d  = '0;
      h_cnt_d   = '0;
      ch_off_d  = '0;
      wb_off_d  = '0;
      h_off_d   = '0;
    end

    // Configuration is captured so the command payload cannot move mid-job.
    if (!working_q && start) begin
      working_d  = 1'b1;
      issued_d   = 1'b0;
      base_d     = base_addr;
      sstride_d  = surface_stride;
      lstride_d  = line_stride;
      ch_max_d   = CH_out_div_Tout - CHG_W'(1);
      h_max_d    = h_out - log2_H'(1);
      wb_max_d   = w_m1[log2_W-1:LEN_W];
      tail_len_d = w_m1[LEN_W-1:0];
      ch_cnt_d   = '0;
      wb_cnt_d   = '0;
      h_cnt_d    = '0;
      ch_off_d   = '0;
      wb_off_d   = '0;
      h_off_d    = '0;
    end
  end

  // Control and datapath state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      working_q  <= 1'b0;
      issued_q   <= 1'b0;
      done_q     <= 1'b0;
      base_q     <= '0;
      sstride_q  <= '0;
      lstride_q  <= '0;
      ch_max_q   <= '0;
      h_max_q    <= '0;
      wb_max_q   <= '0;
      tail_len_q <= '0;
      ch_cnt_q   <= '0;
      wb_cnt_q   <= '0;
      h_cnt_q    <= '0;
      ch_off_q   <= '0;
      wb_off_q   <= '0;
      h_off_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      working_q  <= working_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      base_q     <= base_d;
      sstride_q  <= sstride_d;
      lstride_q  <= lstride_d;
      ch_max_q   <= ch_max_d;
      h_max_q    <= h_max_d;
      wb_max_q   <= wb_max_d;
      tail_len_q <= tail_len_d;
      ch_cnt_q   <= ch_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      h_cnt_q    <= h_cnt_d;
      ch_off_q   <= ch_off_d;
      wb_off_q   <= wb_off_d;
      h_off_q    <= h_off_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_transpose_wdma.sv
// Scoreboard bench for transpose_wdma: directed jobs push expected commands and beats,
// a negedge monitor pops and compares on every accepted handshake.
module tb_transpose_wdma;
  import transpose_wdma_pkg::*;

  typedef struct {
    logic [DAT_W-1:0] pd;
    logic             last;
  } exp_beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       base_addr = '0;
  logic [25:0]       surface_stride = '0;
  logic [15:0]       line_stride = '0;
  logic [CHG_W-1:0]  ch_div = '0;
  logic [log2_H-1:0] h_out = '0;
  logic [log2_W-1:0] w_out = '0;
  logic              t_vld = 1'b0;
  logic              t_rdy;
  logic [DAT_W-1:0]  t_pd = '0;
  logic              req_vld;
  logic              req_rdy = 1'b1;
  logic [REQ_W-1:0]  req_pd;
  logic              dat_vld;
  logic              dat_rdy = 1'b1;
  logic [DAT_W-1:0]  dat_pd;
  logic              dat_last;
  logic              ack = 1'b0;
  logic              working;
  logic              done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_cmd = 0;
  int n_done = 0;
  int last_beat_cyc = 0;
  logic dat_acc = 1'b0;
  logic hold_v = 1'b0;
  logic [REQ_W-1:0] hold_pd = '0;
  wr_req_t got;
  wr_req_t ec;
  exp_beat_t eb;
  wr_req_t exp_cmd_q[$];
  exp_beat_t exp_dat_q[$];
  logic [DAT_W-1:0] src_q[$];
`ifdef TRANSPOSE_WDMA_WR_ACK_EN
  int ack_q[$];
  int ack_delay = 1;
  int last_ack_cyc = 0;
  int done_cyc = 0;
`endif

  transpose_wdma #(
    .CMD_FIFO_DEPTH (4)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .base_addr              (base_addr),
    .surface_stride         (surface_stride),
    .line_stride            (line_stride),
    .CH_out_div_Tout        (ch_div),
    .h_out                  (h_out),
    .w_out                  (w_out),
    .Trans_dat_vld          (t_vld),
    .Trans_dat_rdy          (t_rdy),
    .Trans_dat_pd           (t_pd),
    .Trans2mcif_wr_req_vld  (req_vld),
    .Trans2mcif_wr_req_rdy  (req_rdy),
    .Trans2mcif_wr_req_pd   (req_pd),
    .Trans2mcif_wr_dat_vld  (dat_vld),
    .Trans2mcif_wr_dat_rdy  (dat_rdy),
    .Trans2mcif_wr_dat_pd   (dat_pd),
    .Trans2mcif_wr_dat_last (dat_last),
    .Trans2mcif_wr_ack      (ack),
    .working                (working),
    .done                   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every accepted command / beat against the scoreboard queues.
  always @(negedge clk) begin
    dat_acc = !rst && t_vld && t_rdy;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (req_vld && req_rdy) begin
        got = req_pd;
        if (exp_cmd_q.size() == 0) begin
          check("cmd_unexpected", got, '0);
        end else begin
          ec = exp_cmd_q.pop_front();
          check("cmd_len", got.len, ec.len);
          check("cmd_base", got.base_addr, ec.base_addr);
          check("cmd_offset", got.offset, ec.offset);
        end
        n_cmd++;
      end
      if (req_vld && !req_rdy) begin
        if (hold_v) check("cmd_stable", req_pd, hold_pd);
        hold_v  = 1'b1;
        hold_pd = req_pd;
      end else begin
        hold_v = 1'b0;
      end
      if (dat_vld && dat_rdy) begin
        if (exp_dat_q.size() == 0) begin
          check("beat_unexpected", dat_pd[127:0], '0);
        end else begin
          eb = exp_dat_q.pop_front();
          check("dat_pd_lo", dat_pd[127:0], eb.pd[127:0]);
          check("dat_pd_hi", dat_pd[DAT_W-1:DAT_W-128], eb.pd[DAT_W-1:DAT_W-128]);
          check("dat_last", dat_last, eb.last);
          if (eb.last) begin
            last_beat_cyc = cyc;
`ifdef TRANSPOSE_WDMA_WR_ACK_EN
            ack_q.push_back(cyc + ack_delay);
`endif
          end
        end
      end
`ifdef TRANSPOSE_WDMA_WR_ACK_EN
      if (ack) last_ack_cyc = cyc;
`endif
      if (done) begin
        n_done++;
        check("working_at_done", working, 1'b0);
`ifdef TRANSPOSE_WDMA_WR_ACK_EN
        done_cyc = cyc;
        check("done_after_ack", cyc, last_ack_cyc + 1);
`else
        check("done_latency", cyc, last_beat_cyc + 1);
`endif
      end
    end
  end

  // Source driver: presents queued beats, advances on accept; also issues acks.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (dat_acc && src_q.size() > 0) void'(src_q.pop_front());
`ifdef TRANSPOSE_WDMA_WR_ACK_EN
      ack = (ack_q.size() > 0) && (ack_q[0] == cyc);
      if (ack) void'(ack_q.pop_front());
`endif
      t_vld = (src_q.size() > 0);
      t_pd  = t_vld ? src_q[0] : '0;
    end
  end

  task automatic exp_cmd(input logic [LEN_W-1:0] len, input logic [31:0] base,
                         input logic [31:0] off);
    wr_req_t e;
    e.len       = len;
    e.base_addr = base;
    e.offset    = off;
    exp_cmd_q.push_back(e);
  endtask

  task automatic src_burst(input int n, input int tag, input bit expect_it);
    logic [31:0] word;
    exp_beat_t b;
    for (int i = 0; i < n; i++) begin
      word   = 32'(tag * 256 + i) ^ 32'hA5000000;
      b.pd   = {16{word}};
      b.last = (i == n - 1);
      src_q.push_back(b.pd);
      if (expect_it) exp_dat_q.push_back(b);
    end
  endtask

  task automatic start_job(input logic [CHG_W-1:0] ch, input logic [log2_H-1:0] h,
                           input logic [log2_W-1:0] w, input logic [31:0] base,
                           input logic [25:0] ss, input logic [15:0] ls);
    @(posedge clk);
    #1;
    ch_div         = ch;
    h_out          = h;
    w_out          = w;
    base_addr      = base;
    surface_stride = ss;
    line_stride    = ls;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget);
    int k = 0;
    while (n_done == prev && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    check("done_count", n_done - prev, 1);
    check("cmd_q_drained", exp_cmd_q.size(), 0);
    check("dat_q_drained", exp_dat_q.size(), 0);
    check("idle_after_done", working, 1'b0);
  endtask

  initial begin
    int prev;
    int k;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_working", working, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_req_vld", req_vld, 1'b0);
    check("rst_dat_vld", dat_vld, 1'b0);
    check("rst_dat_last", dat_last, 1'b0);
    check("rst_trans_rdy", t_rdy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single burst
    exp_cmd(3'd7, 32'h1000_0000, 32'h0);
    src_burst(8, 1, 1'b1);
    prev = n_done;
    start_job(3'd1, 8'd1, 8'd8, 32'h1000_0000, 26'h4000, 16'h1000);
    @(negedge clk);
    check("first_cmd_vld", req_vld, 1'b1);
    wait_done(prev, 200);

    // Partial tail: w=10, two channel groups
    exp_cmd(3'd7, 32'h2000_0000, 32'h0000);
    exp_cmd(3'd7, 32'h2000_0000, 32'h4000);
    exp_cmd(3'd1, 32'h2000_0000, 32'h0200);
    exp_cmd(3'd1, 32'h2000_0000, 32'h4200);
    src_burst(8, 2, 1'b1);
    src_burst(8, 3, 1'b1);
    src_burst(2, 4, 1'b1);
    src_burst(2, 5, 1'b1);
    prev = n_done;
    start_job(3'd2, 8'd1, 8'd10, 32'h2000_0000, 26'h4000, 16'h1000);
    wait_done(prev, 300);

    // Rows
    exp_cmd(3'd7, 32'h3000_0000, 32'h0000);
    exp_cmd(3'd7, 32'h3000_0000, 32'h1000);
    exp_cmd(3'd7, 32'h3000_0000, 32'h2000);
    for (int i = 0; i < 3; i++) src_burst(8, 6 + i, 1'b1);
    prev = n_done;
    start_job(3'd1, 8'd3, 8'd8, 32'h3000_0000, 26'h4000, 16'h1000);
    wait_done(prev, 300);

    // Command backpressure: data must not flow before the command is accepted
    req_rdy = 1'b0;
    exp_cmd(3'd7, 32'h4000_0000, 32'h0);
    src_burst(8, 10, 1'b1);
    prev = n_done;
    start_job(3'd1, 8'd1, 8'd8, 32'h4000_0000, 26'h4000, 16'h1000);
    repeat (20) begin
      @(negedge clk);
      check("trans_rdy_blocked", t_rdy, 1'b0);
    end
    @(posedge clk);
    #1;
    req_rdy = 1'b1;
    wait_done(prev, 200);

    // Data backpressure: FIFO fills to 4 and command valid drops
    dat_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_cmd(3'd7, 32'h4100_0000, 32'(i * 32'h100));
      src_burst(8, 20 + i, 1'b1);
    end
    prev = n_done;
    k    = n_cmd;
    start_job(3'd1, 8'd6, 8'd8, 32'h4100_0000, 26'h4000, 16'h0100);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("fifo_fill_cmds", n_cmd - k, 4);
    check("req_vld_when_full", req_vld, 1'b0);
    @(posedge clk);
    #1;
    dat_rdy = 1'b1;
    wait_done(prev, 500);

    // Reset mid-job aborts, then a fresh start replays from offset 0
    dat_rdy = 1'b0;
    for (int i = 0; i < 3; i++) exp_cmd(3'd7, 32'h5000_0000, 32'(i * 32'h1000));
    src_burst(8, 40, 1'b0);
    prev = n_done;
    k    = n_cmd;
    start_job(3'd1, 8'd3, 8'd8, 32'h5000_0000, 26'h4000, 16'h1000);
    for (int i = 0; i < 50 && (n_cmd - k) < 3; i++) @(posedge clk);
    @(negedge clk);
    check("pre_rst_cmds", n_cmd - k, 3);
    check("pre_rst_dat_vld", dat_vld, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_working", working, 1'b0);
    check("midrst_req_vld", req_vld, 1'b0);
    check("midrst_dat_vld", dat_vld, 1'b0);
    check("midrst_dat_last", dat_last, 1'b0);
    check("midrst_done", done, 1'b0);
    src_q.delete();
    @(posedge clk);
    #1;
    rst     = 1'b0;
    dat_rdy = 1'b1;
    repeat (3) @(posedge clk);
    check("no_done_on_abort", n_done - prev, 0);
    for (int i = 0; i < 3; i++) begin
      exp_cmd(3'd7, 32'h5000_0000, 32'(i * 32'h1000));
      src_burst(8, 50 + i, 1'b1);
    end
    prev = n_done;
    start_job(3'd1, 8'd3, 8'd8, 32'h5000_0000, 26'h4000, 16'h1000);
    wait_done(prev, 300);

`ifdef TRANSPOSE_WDMA_WR_ACK_EN
    // Delayed final ack postpones done
    ack_delay = 5;
    exp_cmd(3'd7, 32'h6000_0000, 32'h0);
    src_burst(8, 60, 1'b1);
    prev = n_done;
    start_job(3'd1, 8'd1, 8'd8, 32'h6000_0000, 26'h4000, 16'h1000);
    wait_done(prev, 200);
    check("ack_done_delay", done_cyc - last_beat_cyc, 6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule
